// File: rtl/ifmap_sched_pkg.sv
// ---------------------------------------------------------------------------
// ifmap_sched_pkg
// Shared types and helpers for the ifmap dispatch scheduler:
//   state_t         scheduler FSM states
//   pkt_t           NoC packet layout {rsvd, type, dst, seq, payload}
//   DATA_TYPE_IFMAP packet type code for ifmap traffic
//   row_to_dst()    ifmap row -> PE-row destination byte
// ---------------------------------------------------------------------------
package ifmap_sched_pkg;

   typedef enum logic [1:0] {
      LOAD     = 2'd0,
      GAP_WAIT = 2'd1,
      SEND     = 2'd2,
      FIN      = 2'd3
   } state_t;

   typedef struct packed {
      logic        rsvd;
      logic [1:0]  ptype;
      logic [7:0]  dst;
      logic [7:0]  seq;
      logic [12:0] payload;
   } pkt_t;

   localparam logic [1:0] DATA_TYPE_IFMAP = 2'b01;

   // Rows past the last PE row fold onto it; the low 3 bits then carry
   // the fold index (1, 2, ...) so the PE can tell the rows apart.
   function automatic logic [7:0] row_to_dst(input logic [4:0] row,
                                             input logic [4:0] depth_r);
      logic [4:0] fold;
      fold = row - depth_r + 5'd1;
      if (row < depth_r) return {row, 3'b000};
      else               return {depth_r - 5'd1, fold[2:0]};
   endfunction

endpackage

// File: rtl/ifmap_bitmap.sv
// ---------------------------------------------------------------------------
// ifmap_bitmap
// Flop-based DEPTH x WIDTH spike map with a 1-bit write port and a
// combinational full-row read. Contents are intentionally not reset.
// Ports:
//   clk_i      clock
//   we_i       write enable (out-of-range addresses are ignored)
//   addr_i     linear pixel index row*WIDTH+col
//   data_i     spike bit
//   rd_row_i   row to read (rows >= DEPTH read as zero)
//   rd_bits_o  row contents, bit k = column k
// ---------------------------------------------------------------------------
module ifmap_bitmap #(
   parameter int unsigned DEPTH = 25,
   parameter int unsigned WIDTH = 25
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [9:0]       addr_i,
   input  logic             data_i,
   input  logic [4:0]       rd_row_i,
   output logic [WIDTH-1:0] rd_bits_o
);

   localparam int unsigned NPIX   = DEPTH * WIDTH;
   localparam logic [9:0]  NPIX_V = 10'(NPIX);

   logic [NPIX-1:0] map_q;
   logic [9:0]      base;

   always_ff @(posedge clk_i) begin
      if (we_i && (addr_i < NPIX_V)) map_q[addr_i] <= data_i;
   end

   always_comb begin
      base      = 10'(rd_row_i) * 10'(WIDTH);
      rd_bits_o = '0;
      if (rd_row_i < 5'(DEPTH)) rd_bits_o = map_q[base +: WIDTH];
   end

endmodule

// File: rtl/ifmap_dispatch_sched.sv
// ---------------------------------------------------------------------------
// ifmap_dispatch_sched
// Loads a 25x25 spike map through a write handshake, then streams it to the
// NoC injection port as two packets per row (cols 0-12, then cols 13-24),
// with GAP idle cycles ahead of every packet.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   wr_valid/wr_ready    loader write handshake; wr_addr, wr_data pixel
//   out_valid/out_ready  packet handshake; out_pkt packet
//   busy                 high while dispatching (GAP_WAIT/SEND)
//   done                 one-cycle pulse after the last packet
// Build option:
//   IFMAP_SKIP_ZERO_EN   zero-payload packets are skipped (not presented)
// ---------------------------------------------------------------------------
module ifmap_dispatch_sched
   import ifmap_sched_pkg::*;
#(
   parameter int unsigned DEPTH_I   = 25,
   parameter int unsigned WIDTH_I   = 25,
   parameter int unsigned DEPTH_R   = 21,
   parameter int unsigned GAP       = 4,
   parameter logic [1:0]  DATA_TYPE = DATA_TYPE_IFMAP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [9:0]  wr_addr,
   input  logic        wr_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pkt,
   output logic        busy,
   output logic        done
);

   localparam logic [9:0] NPIX_V   = 10'(DEPTH_I * WIDTH_I);
   localparam logic [4:0] LAST_ROW = 5'(DEPTH_I - 1);
   localparam logic [7:0] GAP_LAST = 8'((GAP > 0) ? GAP - 1 : 0);
`ifdef IFMAP_SKIP_ZERO_EN
   localparam logic       SKIP_EN  = 1'b1;
`else
   localparam logic       SKIP_EN  = 1'b0;
`endif

   state_t     state_q;
   logic [9:0] cnt_q;
   logic [4:0] row_q;
   logic       half_q;
   logic [7:0] gap_q;
   logic       wr_ready_q;
   logic       out_valid_q;
   pkt_t       out_pkt_q;
   logic       busy_q;
   logic       done_q;

   logic [4:0]         adv_row;
   logic               adv_half;
   logic               last_pkt;
   logic [4:0]         rd_row;
   logic               rd_half;
   logic [WIDTH_I-1:0] rd_bits;
   pkt_t               nxt_pkt;
   logic               wr_fire;
   logic               present;
   logic               accept;

   function automatic pkt_t build_pkt(input logic [4:0]  row,
                                      input logic        half,
                                      input logic [24:0] bits);
      pkt_t p;
      p.rsvd    = 1'b0;
      p.ptype   = DATA_TYPE;
      p.dst     = row_to_dst(row, 5'(DEPTH_R));
      p.seq     = {7'b0, half};
      p.payload = half ? {1'b0, bits[24:13]} : bits[12:0];
      return p;
   endfunction

   ifmap_bitmap #(
      .DEPTH (DEPTH_I),
      .WIDTH (WIDTH_I)
   ) u_bitmap (
      .clk_i     (clk),
      .we_i      (wr_fire),
      .addr_i    (wr_addr),
      .data_i    (wr_data),
      .rd_row_i  (rd_row),
      .rd_bits_o (rd_bits)
   );

   // The packet is registered on entry to SEND. From SEND (GAP=0 chaining)
   // the next packet is the advanced row/half; from LOAD/GAP_WAIT the
   // row/half registers already point at it.
   always_comb begin
      adv_half = ~half_q;
      adv_row  = half_q ? row_q + 5'd1 : row_q;
      last_pkt = half_q && (row_q == LAST_ROW);
      rd_row   = (state_q == SEND) ? adv_row  : row_q;
      rd_half  = (state_q == SEND) ? adv_half : half_q;
      nxt_pkt  = build_pkt(rd_row, rd_half, rd_bits);
      wr_fire  = wr_valid && wr_ready_q;
      present  = !SKIP_EN || (nxt_pkt.payload != '0);
      // A skipped packet sits in SEND with out_valid low for one cycle.
      accept   = (state_q == SEND) &&
                 ((out_valid_q && out_ready) || (SKIP_EN && !out_valid_q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         row_q       <= '0;
         half_q      <= 1'b0;
         gap_q       <= '0;
         wr_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_pkt_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (wr_fire && (wr_addr < NPIX_V)) begin
                  cnt_q <= cnt_q + 10'd1;
                  if (cnt_q == NPIX_V - 10'd1) wr_ready_q <= 1'b0;
               end
               if (cnt_q == NPIX_V) begin
                  row_q  <= '0;
                  half_q <= 1'b0;
                  gap_q  <= '0;
                  busy_q <= 1'b1;
                  if (GAP == 0) begin
                     state_q     <= SEND;
                     out_valid_q <= present;
                     out_pkt_q   <= nxt_pkt;
                  end else begin
                     state_q <= GAP_WAIT;
                  end
               end
            end
            GAP_WAIT: begin
               if (gap_q == GAP_LAST) begin
                  gap_q       <= '0;
                  state_q     <= SEND;
                  out_valid_q <= present;
                  out_pkt_q   <= nxt_pkt;
               end else begin
                  gap_q <= gap_q + 8'd1;
               end
            end
            SEND: begin
               if (accept) begin
                  out_valid_q <= 1'b0;
                  if (last_pkt) begin
                     row_q   <= '0;
                     half_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= FIN;
                  end else begin
                     row_q  <= adv_row;
                     half_q <= adv_half;
                     if (GAP == 0) begin
                        out_valid_q <= present;
                        out_pkt_q   <= nxt_pkt;
                     end else begin
                        gap_q   <= '0;
                        state_q <= GAP_WAIT;
                     end
                  end
               end
            end
            FIN: begin
               done_q     <= 1'b0;
               cnt_q      <= '0;
               wr_ready_q <= 1'b1;
               state_q    <= LOAD;
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   assign wr_ready  = wr_ready_q;
   assign out_valid = out_valid_q;
   assign out_pkt   = out_pkt_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ifmap_dispatch_sched.sv
module tb_ifmap_dispatch_sched;

   localparam int GAP = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [9:0]  wr_addr;
   logic        wr_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pkt;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   ifmap_dispatch_sched #(
      .DEPTH_I   (25),
      .WIDTH_I   (25),
      .DEPTH_R   (21),
      .GAP       (GAP),
      .DATA_TYPE (2'b01)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pkt   (out_pkt),
      .busy      (busy),
      .done      (done)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic        tb_map [625];
   logic [31:0] exp_q [$];
   logic [31:0] rx [$];
   int          done_cnt = 0;
   int          cyc = 0;
   int          prev_acc = 0;
   bit          have_prev = 0;
   bit          period_chk = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Independent packet model: dst by arithmetic, payload from the tb map copy.
   function automatic logic [31:0] model_pkt(input int r, input int h);
      int          d;
      logic [12:0] pl;
      d  = (r < 21) ? r * 8 : 20 * 8 + (r - 20);
      pl = '0;
      for (int unsigned k = 0; k < 13; k++) begin
         if (h == 0) pl[k] = tb_map[r * 25 + int'(k)];
         else if (k < 12) pl[k] = tb_map[r * 25 + 13 + int'(k)];
      end
      return {1'b0, 2'b01, 8'(d), 8'(h), pl};
   endfunction

   task automatic push_expected();
      logic [31:0] p;
      for (int r = 0; r < 25; r++) begin
         for (int h = 0; h < 2; h++) begin
            p = model_pkt(r, h);
`ifdef IFMAP_SKIP_ZERO_EN
            if (p[12:0] != 13'd0) exp_q.push_back(p);
`else
            exp_q.push_back(p);
`endif
         end
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
         else check_eq("sb_pkt", out_pkt, exp_q.pop_front());
         rx.push_back(out_pkt);
         if (period_chk && have_prev) check_eq("period", 32'(cyc - prev_acc), 32'(GAP + 1));
         prev_acc  = cyc;
         have_prev = 1;
      end
   end

   task automatic wr(input logic [9:0] a, input logic d);
      int t = 0;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      while (!wr_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) check_eq("wr_timeout", 32'(t), 32'd0);
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic load_frame(input bit chk);
      for (int a = 0; a < 625; a++) begin
         if (chk && a == 624) begin
            check_eq("wr_ready_pre", 32'(wr_ready), 32'd1);
            check_eq("busy_pre", 32'(busy), 32'd0);
         end
         wr(10'(a), tb_map[a]);
      end
      if (chk) check_eq("wr_ready_post", 32'(wr_ready), 32'd0);
      push_expected();
   endtask

   task automatic finish_frame();
      int t = 0;
      while (done_cnt == 0 && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (4) begin @(posedge clk); #1; end
      check_eq("done_pulses", 32'(done_cnt), 32'd1);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_wr_ready", 32'(wr_ready), 32'd1);
   endtask

   task automatic new_frame();
      rx.delete();
      done_cnt  = 0;
      have_prev = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      int          t;
      logic [31:0] snap;

      rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = 1'b0; out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_pkt", out_pkt, 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: all ones, latency and pacing
      new_frame();
      for (int a = 0; a < 625; a++) tb_map[a] = 1'b1;
      load_frame(1'b0);
      period_chk = 1;
      k = 0;
      while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
      check_eq("latency", 32'(k), 32'(GAP + 1));
      check_eq("busy_dispatch", 32'(busy), 32'd1);
      finish_frame();
      period_chk = 0;
      check_eq("t1_count", 32'(rx.size()), 32'd50);
      check_eq("t1_row0_lo", rx[0], 32'h20001FFF);
      check_eq("t1_row0_hi", rx[1], 32'h20002FFF);

      // 2: single spike at row 22 col 20
      new_frame();
      for (int a = 0; a < 625; a++) tb_map[a] = 1'b0;
      tb_map[570] = 1'b1;
      load_frame(1'b0);
      finish_frame();
`ifndef IFMAP_SKIP_ZERO_EN
      check_eq("t2_row22_hi", rx[45], 32'h34402080);
      check_eq("t2_row5_dst", 32'(rx[10][28:21]), 32'h28);
`else
      check_eq("t2_count", 32'(rx.size()), 32'd1);
      check_eq("t2_row22_hi", rx[0], 32'h34402080);
`endif

      // 3: backpressure stall on row 1 hi
      new_frame();
      for (int a = 0; a < 625; a++) tb_map[a] = 1'((a / 25 + a % 25) % 2 == 0);
      load_frame(1'b0);
      t = 0;
      while (rx.size() < 3 && t < 500) begin @(posedge clk); #1; t++; end
      out_ready = 1'b0;
      t = 0;
      while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
      snap = out_pkt;
      repeat (10) begin @(posedge clk); #1; end
      check_eq("stall_pkt", out_pkt, snap);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_no_adv", 32'(rx.size()), 32'd3);
      check_eq("stall_seq", 32'(snap[20:13]), 32'd1);
      out_ready = 1'b1;
      finish_frame();

      // 4: out-of-range write dropped, dispatch only after 625th valid write
      new_frame();
      for (int a = 0; a < 625; a++) tb_map[a] = 1'($urandom_range(0, 1));
      wr(10'd700, 1'b1);
      load_frame(1'b1);
      finish_frame();

      // 5: reset during row 10
      new_frame();
      for (int a = 0; a < 625; a++) tb_map[a] = 1'((a % 7) != 0);
      load_frame(1'b0);
      t = 0;
      while (rx.size() < 21 && t < 1000) begin @(posedge clk); #1; t++; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("rst5_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst5_busy", 32'(busy), 32'd0);
      check_eq("rst5_wr_ready", 32'(wr_ready), 32'd1);
      exp_q.delete();
      new_frame();
      for (int a = 0; a < 625; a++) tb_map[a] = 1'((a % 5) == 1);
      load_frame(1'b1);
      finish_frame();
`ifndef IFMAP_SKIP_ZERO_EN
      check_eq("t5_count", 32'(rx.size()), 32'd50);
      check_eq("t5_first_seq", 32'(rx[0][20:13]), 32'd0);
`endif

`ifdef IFMAP_SKIP_ZERO_EN
      // 6: only row 3 col 0 set -> single packet
      new_frame();
      for (int a = 0; a < 625; a++) tb_map[a] = 1'b0;
      tb_map[75] = 1'b1;
      load_frame(1'b0);
      finish_frame();
      check_eq("t6_count", 32'(rx.size()), 32'd1);
      check_eq("t6_pkt", rx[0], 32'h23000001);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
